fp_norm_24: RTL
===============

FP_NORM_24 -- requirements
Module: fp_norm_24

Interface
REQ-001 The block SHALL have these ports, one clock, asynchronous active-low reset:
- iClk  in  1  clock, rising edge
- iRstn  in  1  asynchronous active-low reset
- iValid  in  1  upstream mantissa difference valid
- oReady  out  1  block can accept; high only in IDLE
- iMant  in  24  unsigned mantissa difference (output of the 24-bit CLA subtractor)
- iExp  in  8  biased exponent of the larger operand
- iSign  in  1  result sign
- oValid  out  1  normalized result valid
- iReady  in  1  downstream accepts result
- oMant  out  24  normalized mantissa
- oExp  out  8  adjusted biased exponent
- oSign  out  1  registered copy of iSign
- oZero  out  1  result is exact zero
- oUnder  out  1  result is denormal (exponent clamped to 0)

Function
REQ-002 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-003 IDLE SHALL hold oReady=1 and oValid=0; iValid=1 at a rising edge SHALL capture iMant, iExp and iSign.
REQ-004 On capture:
- iMant==0 SHALL go to DONE with oMant=0, oExp=0, oZero=1.
- iMant[23]==1 SHALL go to DONE with the mantissa and exponent unchanged.
- iExp<=1 with iMant[23]==0 SHALL go to DONE with oExp=0, oUnder=1 and the mantissa unshifted.
- All other cases SHALL go to SHIFT.
REQ-005 Each SHIFT cycle SHALL compute k = min(leading zeros of the mantissa, 4, exp-1), shift the mantissa left by k with zero fill, and subtract k from exp.
REQ-006 After a step, SHIFT SHALL exit as follows:
- mant[23]==1 SHALL go to DONE.
- Otherwise exp==1 SHALL go to DONE with the exponent forced to 0 and oUnder=1.
- Otherwise the block SHALL remain in SHIFT.
REQ-007 Latency: oValid SHALL rise 1 cycle after the capture edge plus one cycle per SHIFT step, with at most 6 steps (maximum 7 cycles).
REQ-008 DONE SHALL hold oValid=1 with oMant, oExp, oSign, oZero and oUnder stable.
REQ-009 While iReady=0, the state and all outputs SHALL be held unchanged.
REQ-010 The edge on which oValid=1 and iReady=1 SHALL return the block to IDLE.
REQ-011 oReady SHALL be 0 in SHIFT and DONE; iValid in those states SHALL be ignored and no data captured.
REQ-012 A new capture SHALL occur no earlier than the cycle after the DONE-to-IDLE transition, so there is one idle bubble per transaction.
REQ-013 oExp SHALL never wrap below 0; exponent arithmetic SHALL be 8-bit unsigned, with the guaranteed property k <= exp-1.
REQ-014 oZero and oUnder SHALL be mutually exclusive and SHALL be 0 when oValid=0.

Reset
REQ-015 iRstn low SHALL immediately, independent of iClk, force:
- state to IDLE
- oValid=0 and oReady=1
- oMant, oExp, oSign, oZero and oUnder to 0
REQ-016 Reset asserted during SHIFT or DONE SHALL discard the in-flight transaction with no output pulse.
REQ-017 The first capture after iRstn deasserts SHALL be possible on the first rising edge.

Configuration
REQ-018 Macro FP_NORM_FAST_EN defined: on capture the block SHALL compute the full leading-zero count (clamped to exp-1) and barrel-shift in one cycle, going directly to DONE.
- Latency SHALL be 1 cycle for all inputs.
- The SHIFT state SHALL be unreachable.
- Results SHALL be bit-identical to the iterative mode.
REQ-019 Macro FP_NORM_FAST_EN undefined: the iterative 4-bit-per-cycle behaviour of REQ-005 to REQ-007 SHALL apply.

Verification
REQ-020 iMant=0x800000, iExp=0x7F, iSign=1, iReady=1 -> oValid 1 cycle after capture, with:
- oMant=0x800000, oExp=0x7F, oSign=1
- oZero=0, oUnder=0
REQ-021 iMant=0x000001, iExp=0x80 -> oMant=0x800000, oExp=0x69.
- Iterative: oValid 7 cycles after capture, 6 SHIFT steps (4,4,4,4,4,3).
- FP_NORM_FAST_EN: oValid 1 cycle after capture.
REQ-022 iMant=0x000100, iExp=0x05 -> one step of 4, then:
- oMant=0x001000, oExp=0x00, oUnder=1, oZero=0.
REQ-023 iMant=0x000000, iExp=0x90, iSign=0 -> oZero=1, oMant=0, oExp=0, oUnder=0, oValid 1 cycle after capture.
REQ-024 Result in DONE with iReady=0 for 5 cycles and iValid=1 held -> the following SHALL hold:
- Outputs stable and oReady=0 throughout.
- No capture occurs.
- iReady=1 returns the block to IDLE.
- The next iValid is captured one cycle later.
REQ-025 iRstn pulsed low during the 3rd SHIFT cycle of the REQ-021 stimulus -> oValid=0 and oReady=1 without waiting for a clock edge, and no result is emitted afterwards.

Source files
------------

// File: rtl/fp_norm_24.sv
// fp_norm_24: normalizes a 24-bit mantissa difference, 4 bits per cycle.
// Define FP_NORM_FAST_EN for single-cycle full-width normalization.
module fp_norm_24 (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iValid,
  output logic        oReady,
  input  logic [23:0] iMant,
  input  logic [7:0]  iExp,
  input  logic        iSign,
  output logic        oValid,
  input  logic        iReady,
  output logic [23:0] oMant,
  output logic [7:0]  oExp,
  output logic        oSign,
  output logic        oZero,
  output logic        oUnder
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
`ifdef FP_NORM_FAST_EN
  localparam logic [7:0] CAP = 8'd24;
`else
  localparam logic [7:0] CAP = 8'd4;
`endif
  logic [1:0]  state;
  logic [23:0] mant, src_m, sh_m;
  logic [7:0]  expo, src_e, lz, em1, k, sh_e, fin_e;
  logic        sign, zero, under, fin_u, fin;
  // One normalization step; the exponent clamp keeps k <= exp-1 so exp never wraps.
  always_comb begin
    src_m = state == IDLE ? iMant : mant;
    src_e = state == IDLE ? iExp : expo;
    lz = 8'd24;
    for (int i = 0; i < 24; i++) if (src_m[i]) lz = 8'(23 - i);
    em1 = src_e - 8'd1;
    k = lz < CAP ? lz : CAP;
    k = k < em1 ? k : em1;
    sh_m = src_m << k;
    sh_e = src_e - k;
    fin_u = !sh_m[23] && sh_e == 8'd1;
    fin = sh_m[23] || fin_u;
    fin_e = fin_u ? 8'd0 : sh_e;
  end
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state <= IDLE;
      mant  <= '0;
      expo  <= '0;
      sign  <= 1'b0;
      zero  <= 1'b0;
      under <= 1'b0;
    end else begin
      case (state)
        IDLE: if (iValid) begin
          sign  <= iSign;
          zero  <= 1'b0;
          under <= 1'b0;
          if (iMant == 24'd0) begin
            mant  <= '0;
            expo  <= '0;
            zero  <= 1'b1;
            state <= DONE;
          end else if (iMant[23]) begin
            mant  <= iMant;
            expo  <= iExp;
            state <= DONE;
          end else if (iExp < 8'd2) begin
            mant  <= iMant;
            expo  <= '0;
            under <= 1'b1;
            state <= DONE;
          end else begin
`ifdef FP_NORM_FAST_EN
            mant  <= sh_m;
            expo  <= fin_e;
            under <= fin_u;
            state <= DONE;
`else
            mant  <= iMant;
            expo  <= iExp;
            state <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          mant  <= sh_m;
          expo  <= fin_e;
          under <= fin_u;
          state <= fin ? DONE : SHIFT;
        end
        DONE: if (iReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign oReady = state == IDLE;
  assign oValid = state == DONE;
  assign oMant  = mant;
  assign oExp   = expo;
  assign oSign  = sign;
  assign oZero  = zero & oValid;
  assign oUnder = under & oValid;
endmodule
